dht11_bcd_fmt: RTL and testbench
================================

// Module: dht11_bcd_fmt
// PURPOSE
//  Downstream of the DHT11 reader. Takes each checksum-valid 32-bit sample
//  {hum_int, hum_dec, temp_int, temp_dec} and converts all four bytes to
//  3-digit BCD with one shared sequential double-dabble engine. Presents the
//  result to the display/UART stage over a valid/ready handshake.
//  Also flags stale sensor data and out-of-range decimal bytes.
// PARAMETERS
//  STALE_CYCLES  150_000_000  clk cycles without in_stb before stale=1 (3 s @ 50 MHz)
//  CHECK_DEC     1            1: dec_err flags decimal byte >9; 0: dec_err tied 0
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  in_data      in   32  [31:24] hum_int, [23:16] hum_dec, [15:8] temp_int, [7:0] temp_dec
//  in_stb       in   1   1-cycle pulse: in_data holds a new valid sample
//  out_ready    in   1   consumer accepts result
//  out_valid    out  1   result valid; all out fields stable while high
//  hum_int_bcd  out  12  3 BCD digits, hundreds in [11:8]
//  hum_dec_bcd  out  12  as above
//  temp_int_bcd out  12  as above
//  temp_dec_bcd out  12  as above
//  dec_err      out  1   hum_dec>9 or temp_dec>9 in the presented sample
//  busy         out  1   conversion in progress (state SHIFT/STORE)
//  overrun      out  1   1-cycle pulse: pending sample overwritten
//  stale        out  1   no in_stb for STALE_CYCLES cycles
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, pending slot empty, stale counter 0.
//  FSM: IDLE -> SHIFT -> STORE -> (SHIFT | OUT) -> (IDLE | SHIFT).
//  IDLE: on in_stb, capture in_data into the work word, byte_idx=0, go to SHIFT.
//  SHIFT: 8 cycles per byte. Each cycle: add 3 to every BCD nibble >=5,
//   then shift left 1 with the byte MSB in.
//  STORE: 1 cycle. Write 12-bit BCD to the shadow field for byte_idx.
//   Clear the accumulator, load next byte, byte_idx++.
//   After byte 3, go to OUT.
//  Timing: in_stb sampled at edge N -> output fields, dec_err and out_valid=1
//   all update together at edge N+36. Outputs never update partially.
//  OUT: out_valid held until out_valid&out_ready at an edge; it falls there.
//   If pending is full, start the pending word (SHIFT); otherwise go to IDLE.
//   Output fields hold their last values after out_valid falls,
//   until the next commit.
//  in_stb outside IDLE: store in_data in the 1-deep pending slot.
//   If the slot is already full, overwrite it and pulse overrun.
//  in_stb at the same edge that a pending word is consumed: the pending word
//   starts, in_stb fills the freed slot, no overrun.
//  in_stb at a handshake edge with the slot empty: in_stb fills the slot and
//   starts at that edge (equivalent to an IDLE start).
//  stale: counter increments each cycle and saturates at STALE_CYCLES.
//   stale=1 when the counter equals STALE_CYCLES. in_stb clears the counter
//   and stale at that edge.
//  Width: bytes are 0..255; hundreds digit is 0..2; no overflow is possible.
//  Reset mid-conversion: immediate return to reset values; pending sample lost.
// TESTING
//  1 in_data=0x3700_1A00, stb, out_ready=1 -> edge N+36: hum_int=0x055,
//    temp_int=0x026, decs=0x000, dec_err=0; out_valid high 1 cycle.
//  2 in_data=0xFF09_3209 -> hum_int=0x255, hum_dec=0x009, temp_int=0x050,
//    temp_dec=0x009, dec_err=0.
//  3 in_data=0x2D0A_1400 -> hum_dec=0x010, dec_err=1; with CHECK_DEC=0,
//    dec_err=0.
//  4 out_ready=0, three stb during busy/OUT -> one overrun pulse; raise
//    out_ready -> exactly 2 results: first sample, then the last sample.
//  5 STALE_CYCLES=100, no stb -> stale rises at cycle 100; stb -> stale=0
//    next edge.
//  6 rst_n low at edge N+20 of a conversion -> all outputs 0, no out_valid;
//    next stb converts normally in 36 cycles.

Source files
------------

// File: rtl/dht11_bcd_fmt_if.sv
// Result handshake bundle between the DHT11 BCD formatter and its consumer.
// master drives samples and ready; slave is the formatter.
interface dht11_bcd_fmt_if;
   logic [31:0] in_data;
   logic        in_stb;
   logic        out_ready;
   logic        out_valid;
   logic [11:0] hum_int_bcd;
   logic [11:0] hum_dec_bcd;
   logic [11:0] temp_int_bcd;
   logic [11:0] temp_dec_bcd;
   logic        dec_err;
   logic        busy;
   logic        overrun;
   logic        stale;

   modport master (
      output in_data, in_stb, out_ready,
      input  out_valid, hum_int_bcd, hum_dec_bcd, temp_int_bcd, temp_dec_bcd,
      input  dec_err, busy, overrun, stale
   );

   modport slave (
      input  in_data, in_stb, out_ready,
      output out_valid, hum_int_bcd, hum_dec_bcd, temp_int_bcd, temp_dec_bcd,
      output dec_err, busy, overrun, stale
   );
endinterface

// File: rtl/dht11_bcd_fmt.sv
// Converts each DHT11 sample's four bytes to 3-digit BCD with one shared
// sequential double-dabble engine; 1-deep pending slot, stale-data timer.
module dht11_bcd_fmt #(
   parameter int unsigned STALE_CYCLES = 150_000_000,
   parameter bit          CHECK_DEC    = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   dht11_bcd_fmt_if.slave bus
);

   localparam int unsigned StaleW = $clog2(STALE_CYCLES + 1);
   localparam logic [StaleW-1:0] StaleMax = StaleW'(STALE_CYCLES);

   typedef enum logic [1:0] {StIdle, StShift, StStore, StOut} state_e;

   state_e      state_q, state_d;
   logic [31:0] work_q, work_d;
   logic [11:0] acc_q, acc_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [11:0] hum_int_sh_q, hum_int_sh_d;
   logic [11:0] hum_dec_sh_q, hum_dec_sh_d;
   logic [11:0] temp_int_sh_q, temp_int_sh_d;
   logic [31:0] pend_q, pend_d;
   logic        pend_full_q, pend_full_d;
   logic        out_valid_q, out_valid_d;
   logic [11:0] hum_int_q, hum_int_d;
   logic [11:0] hum_dec_q, hum_dec_d;
   logic [11:0] temp_int_q, temp_int_d;
   logic [11:0] temp_dec_q, temp_dec_d;
   logic        dec_err_q, dec_err_d;
   logic        overrun_q, overrun_d;
   logic [StaleW-1:0] stale_cnt_q, stale_cnt_d;

   logic [11:0] acc_adj;
   logic        start;
   logic [31:0] start_word;
   logic        handshake;

   function automatic logic [11:0] add3(input logic [11:0] v);
      logic [11:0] r;
      for (int i = 0; i < 3; i++) begin
         r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
      end
      return r;
   endfunction

   assign acc_adj   = add3(acc_q);
   assign handshake = (state_q == StOut) && bus.out_ready;

   always_comb begin
      state_d       = state_q;
      work_d        = work_q;
      acc_d         = acc_q;
      bit_cnt_d     = bit_cnt_q;
      byte_idx_d    = byte_idx_q;
      hum_int_sh_d  = hum_int_sh_q;
      hum_dec_sh_d  = hum_dec_sh_q;
      temp_int_sh_d = temp_int_sh_q;
      pend_d        = pend_q;
      pend_full_d   = pend_full_q;
      out_valid_d   = out_valid_q;
      hum_int_d     = hum_int_q;
      hum_dec_d     = hum_dec_q;
      temp_int_d    = temp_int_q;
      temp_dec_d    = temp_dec_q;
      dec_err_d     = dec_err_q;
      overrun_d     = 1'b0;
      stale_cnt_d   = stale_cnt_q;
      start         = 1'b0;
      start_word    = bus.in_data;

      unique case (state_q)
         StIdle: begin
            if (bus.in_stb) begin
               start      = 1'b1;
               start_word = bus.in_data;
            end
         end
         StShift: begin
            // Whole work word shifts, so the next byte is already on top at STORE.
            acc_d     = {acc_adj[10:0], work_q[31]};
            work_d    = {work_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = StStore;
         end
         StStore: begin
            acc_d      = '0;
            bit_cnt_d  = '0;
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = StShift;
            unique case (byte_idx_q)
               2'd0: hum_int_sh_d  = acc_q;
               2'd1: hum_dec_sh_d  = acc_q;
               2'd2: temp_int_sh_d = acc_q;
               default: begin
                  // Last byte commits all four fields at once.
                  hum_int_d   = hum_int_sh_q;
                  hum_dec_d   = hum_dec_sh_q;
                  temp_int_d  = temp_int_sh_q;
                  temp_dec_d  = acc_q;
                  dec_err_d   = CHECK_DEC & ((|hum_dec_sh_q[11:4]) | (|acc_q[11:4]));
                  out_valid_d = 1'b1;
                  state_d     = StOut;
               end
            endcase
         end
         default: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (pend_full_q) begin
                  start       = 1'b1;
                  start_word  = pend_q;
                  pend_full_d = 1'b0;
               end else if (bus.in_stb) begin
                  start      = 1'b1;
                  start_word = bus.in_data;
               end else begin
                  state_d = StIdle;
               end
            end
         end
      endcase

      if (start) begin
         state_d    = StShift;
         work_d     = start_word;
         acc_d      = '0;
         bit_cnt_d  = '0;
         byte_idx_d = '0;
      end

      // A strobe that is not started directly lands in the pending slot.
      if (bus.in_stb && (state_q != StIdle)) begin
         if (handshake) begin
            if (pend_full_q) begin
               pend_d      = bus.in_data;
               pend_full_d = 1'b1;
            end
         end else begin
            pend_d      = bus.in_data;
            pend_full_d = 1'b1;
            overrun_d   = pend_full_q;
         end
      end

      if (bus.in_stb) stale_cnt_d = '0;
      else if (stale_cnt_q != StaleMax) stale_cnt_d = stale_cnt_q + StaleW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         work_q        <= '0;
         acc_q         <= '0;
         bit_cnt_q     <= '0;
         byte_idx_q    <= '0;
         hum_int_sh_q  <= '0;
         hum_dec_sh_q  <= '0;
         temp_int_sh_q <= '0;
         pend_q        <= '0;
         pend_full_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         hum_int_q     <= '0;
         hum_dec_q     <= '0;
         temp_int_q    <= '0;
         temp_dec_q    <= '0;
         dec_err_q     <= 1'b0;
         overrun_q     <= 1'b0;
         stale_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         work_q        <= work_d;
         acc_q         <= acc_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_idx_q    <= byte_idx_d;
         hum_int_sh_q  <= hum_int_sh_d;
         hum_dec_sh_q  <= hum_dec_sh_d;
         temp_int_sh_q <= temp_int_sh_d;
         pend_q        <= pend_d;
         pend_full_q   <= pend_full_d;
         out_valid_q   <= out_valid_d;
         hum_int_q     <= hum_int_d;
         hum_dec_q     <= hum_dec_d;
         temp_int_q    <= temp_int_d;
         temp_dec_q    <= temp_dec_d;
         dec_err_q     <= dec_err_d;
         overrun_q     <= overrun_d;
         stale_cnt_q   <= stale_cnt_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.hum_int_bcd  = hum_int_q;
   assign bus.hum_dec_bcd  = hum_dec_q;
   assign bus.temp_int_bcd = temp_int_q;
   assign bus.temp_dec_bcd = temp_dec_q;
   assign bus.dec_err      = dec_err_q;
   assign bus.busy         = (state_q == StShift) || (state_q == StStore);
   assign bus.overrun      = overrun_q;
   assign bus.stale        = (stale_cnt_q == StaleMax);

endmodule

// File: tb/tb_dht11_bcd_fmt.sv
// Directed bench for dht11_bcd_fmt; a second instance with CHECK_DEC=0 shadows
// the main one on the same inputs.
module tb_dht11_bcd_fmt;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   dht11_bcd_fmt_if bus ();
   dht11_bcd_fmt_if bus_nd ();

   assign bus_nd.in_data   = bus.in_data;
   assign bus_nd.in_stb    = bus.in_stb;
   assign bus_nd.out_ready = bus.out_ready;

   dht11_bcd_fmt #(.STALE_CYCLES(100), .CHECK_DEC(1'b1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   dht11_bcd_fmt #(.STALE_CYCLES(100), .CHECK_DEC(1'b0)) u_dut_nd (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_nd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Pulse in_stb for one edge; returns #1 after that edge.
   task automatic send(input logic [31:0] d);
      bus.in_data = d;
      bus.in_stb  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_stb = 1'b0;
   endtask

   // Edges until out_valid is seen (0 if not within budget).
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic check_fields(input string tag, input logic [11:0] hi, input logic [11:0] hd,
                               input logic [11:0] ti, input logic [11:0] td, input logic de);
      check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_hum_int"}, 32'(bus.hum_int_bcd), 32'(hi));
      check_eq({tag, "_hum_dec"}, 32'(bus.hum_dec_bcd), 32'(hd));
      check_eq({tag, "_temp_int"}, 32'(bus.temp_int_bcd), 32'(ti));
      check_eq({tag, "_temp_dec"}, 32'(bus.temp_dec_bcd), 32'(td));
      check_eq({tag, "_dec_err"}, 32'(bus.dec_err), 32'(de));
      check_eq({tag, "_dec_err_nochk"}, 32'(bus_nd.dec_err), 32'd0);
   endtask

   initial begin
      int lat;
      int nval;
      n_chk         = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bus.in_data   = '0;
      bus.in_stb    = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_hum_int", 32'(bus.hum_int_bcd), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
      check_eq("rst_stale", 32'(bus.stale), 32'd0);
      rst_n = 1'b1;

      // Stale timer: rises after 100 edges without a strobe, then saturates
      repeat (99) @(posedge clk);
      #1;
      check_eq("stale_99", 32'(bus.stale), 32'd0);
      @(posedge clk);
      #1;
      check_eq("stale_100", 32'(bus.stale), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check_eq("stale_sat", 32'(bus.stale), 32'd1);

      // Basic conversion, latency 36, one-cycle valid with ready high
      send(32'h3700_1A00);
      check_eq("stale_clr", 32'(bus.stale), 32'd0);
      check_eq("t1_busy", 32'(bus.busy), 32'd1);
      wait_valid(lat);
      check_eq("t1_latency", 32'(lat), 32'd36);
      check_fields("t1", 12'h055, 12'h000, 12'h026, 12'h000, 1'b0);
      @(posedge clk);
      #1;
      check_eq("t1_valid_fall", 32'(bus.out_valid), 32'd0);
      check_eq("t1_hold", 32'(bus.hum_int_bcd), 32'h055);

      // Maximum byte values
      send(32'hFF09_3209);
      wait_valid(lat);
      check_eq("t2_latency", 32'(lat), 32'd36);
      check_fields("t2", 12'h255, 12'h009, 12'h050, 12'h009, 1'b0);
      @(posedge clk);
      #1;

      // Decimal byte out of range
      send(32'h2D0A_1400);
      wait_valid(lat);
      check_eq("t3_latency", 32'(lat), 32'd36);
      check_fields("t3", 12'h045, 12'h010, 12'h020, 12'h000, 1'b1);
      @(posedge clk);
      #1;

      // Backpressure: A converts, B pends, C overwrites B with one overrun pulse
      bus.out_ready = 1'b0;
      send(32'h0102_0304);
      repeat (3) @(posedge clk);
      #1;
      send(32'h1111_1111);
      check_eq("t4_ovr_b", 32'(bus.overrun), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      send(32'h6307_5808);
      check_eq("t4_ovr_c", 32'(bus.overrun), 32'd1);
      @(posedge clk);
      #1;
      check_eq("t4_ovr_pulse", 32'(bus.overrun), 32'd0);
      wait_valid(lat);
      check_fields("t4a", 12'h001, 12'h002, 12'h003, 12'h004, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("t4_valid_held", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("t4_valid_fall", 32'(bus.out_valid), 32'd0);
      check_eq("t4_pend_start", 32'(bus.busy), 32'd1);
      wait_valid(lat);
      check_eq("t4_pend_latency", 32'(lat), 32'd36);
      check_fields("t4c", 12'h099, 12'h007, 12'h088, 12'h008, 1'b0);
      nval = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) nval++;
      end
      check_eq("t4_no_third", 32'(nval), 32'd0);

      // Reset in the middle of a conversion
      send(32'h2222_2222);
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("t6_busy", 32'(bus.busy), 32'd0);
      check_eq("t6_valid", 32'(bus.out_valid), 32'd0);
      check_eq("t6_hum_int", 32'(bus.hum_int_bcd), 32'd0);
      check_eq("t6_temp_int", 32'(bus.temp_int_bcd), 32'd0);
      check_eq("t6_dec_err", 32'(bus.dec_err), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      nval  = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) nval++;
      end
      check_eq("t6_no_valid", 32'(nval), 32'd0);
      send(32'h4105_1902);
      wait_valid(lat);
      check_eq("t6_latency", 32'(lat), 32'd36);
      check_fields("t6", 12'h065, 12'h005, 12'h025, 12'h002, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
